// File: rtl/ps2_pkg.sv
// Shared PS/2 definitions: receiver FSM states, frame geometry and the
// scan-code constants the downstream keyboard decoder reuses.
package ps2_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DATA   = 2'd1,
        PARITY = 2'd2,
        STOP   = 2'd3
    } ps2_state_e;

    localparam int FRAME_BITS = 11;
    localparam int DATA_BITS  = 8;

    localparam logic [7:0] SC_EXT   = 8'hE0;
    localparam logic [7:0] SC_BREAK = 8'hF0;
    localparam logic [7:0] SC_ENTER = 8'h5A;
    localparam logic [7:0] SC_LEFT  = 8'h6B;
    localparam logic [7:0] SC_RIGHT = 8'h74;

    // Odd parity holds when data bits plus parity bit contain an odd number of ones.
    function automatic logic odd_parity_ok(input logic [7:0] data, input logic parity);
        return ^{data, parity};
    endfunction

endpackage

// File: rtl/ps2_line_filter.sv
// PS/2 line conditioning: two-flop synchronizers on clock and data, a
// FILTER_LEN-sample glitch filter on the clock and a registered one-cycle
// falling-edge pulse of the filtered clock. Everything resets high because
// both lines idle high, so reset release never fakes an edge.
module ps2_line_filter #(
    parameter int FILTER_LEN = 8
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic ps2_clk_i,
    input  logic ps2_dat_i,
    output logic dat_sync_o,
    output logic fall_edge_o
);

    localparam int CW = (FILTER_LEN < 2) ? 1 : $clog2(FILTER_LEN);

    logic          clkMeta_q, clkSync_q;
    logic          datMeta_q, datSync_q;
    logic [CW-1:0] filtCnt_q, filtCnt_d;
    logic          filtLevel_q, filtLevel_d;
    logic          filtLevelPrev_q;
    logic          fallEdge_q;

    // Metastability synchronizers for both asynchronous PS/2 lines.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            clkMeta_q <= 1'b1;
            clkSync_q <= 1'b1;
            datMeta_q <= 1'b1;
            datSync_q <= 1'b1;
        end else begin
            clkMeta_q <= ps2_clk_i;
            clkSync_q <= clkMeta_q;
            datMeta_q <= ps2_dat_i;
            datSync_q <= datMeta_q;
        end
    end

    // Count consecutive samples that disagree with the filtered level; flip it on the FILTER_LEN-th.
    always_comb begin
        filtCnt_d   = filtCnt_q;
        filtLevel_d = filtLevel_q;
        if (clkSync_q == filtLevel_q) begin
            filtCnt_d = '0;
        end else if (filtCnt_q == CW'(FILTER_LEN - 1)) begin
            filtLevel_d = clkSync_q;
            filtCnt_d   = '0;
        end else begin
            filtCnt_d = filtCnt_q + 1'b1;
        end
    end

    // Filter state plus a registered 1->0 detector on the filtered clock.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            filtCnt_q       <= '0;
            filtLevel_q     <= 1'b1;
            filtLevelPrev_q <= 1'b1;
            fallEdge_q      <= 1'b0;
        end else begin
            filtCnt_q       <= filtCnt_d;
            filtLevel_q     <= filtLevel_d;
            filtLevelPrev_q <= filtLevel_q;
            fallEdge_q      <= filtLevelPrev_q & ~filtLevel_q;
        end
    end

    assign dat_sync_o  = datSync_q;
    assign fall_edge_o = fallEdge_q;

endmodule

// File: rtl/ps2_frame_receiver.sv
// Receive-only PS/2 device-to-host deserializer. Assembles start, 8 data
// bits (LSB first), odd parity and stop into a byte with a one-cycle strobe,
// aborts stalled frames with a watchdog, and never drives the PS/2 lines.
// Optional macro PS2_PARITY_CHECK_EN: when defined, frames with bad odd
// parity are rejected; otherwise the parity bit is captured but ignored.
module ps2_frame_receiver
    import ps2_pkg::*;
#(
    parameter int CLK_FREQ_HZ = 50000000,
    parameter int TIMEOUT_US  = 2000,
    parameter int FILTER_LEN  = 8
) (
    input  logic       CLOCK_50,
    input  logic       resetn,
    inout  wire        PS2_CLK,
    inout  wire        PS2_DAT,
    output logic [7:0] received_data,
    output logic       received_data_en,
    output logic       frame_error,
    output logic       busy
);

    localparam int WD_TC = CLK_FREQ_HZ / 1000000 * TIMEOUT_US;
    localparam int WD_W  = $clog2(WD_TC + 1);

    assign PS2_CLK = 1'bz;
    assign PS2_DAT = 1'bz;

    logic datSync;
    logic fallEdge;

    ps2_line_filter #(
        .FILTER_LEN (FILTER_LEN)
    ) u_line_filter (
        .clk_i       (CLOCK_50),
        .rst_ni      (resetn),
        .ps2_clk_i   (PS2_CLK),
        .ps2_dat_i   (PS2_DAT),
        .dat_sync_o  (datSync),
        .fall_edge_o (fallEdge)
    );

    ps2_state_e      state_q, state_d;
    logic [2:0]      bitCnt_q, bitCnt_d;
    logic [7:0]      shift_q, shift_d;
    logic            parity_q, parity_d;
    logic [WD_W-1:0] wd_q, wd_d;
    logic [7:0]      rxData_q, rxData_d;
    logic            rxEn_q, rxEn_d;
    logic            frameErr_q, frameErr_d;
    logic            timeout;
    logic            parityOk;
    logic            frameValid;

    // Parity acceptance for the frame being closed by the stop bit.
    always_comb begin
`ifdef PS2_PARITY_CHECK_EN
        parityOk = odd_parity_ok(shift_q, parity_q);
`else
        parityOk = parity_q | 1'b1;
`endif
    end

    assign timeout    = (state_q != IDLE) && (wd_q == WD_W'(WD_TC - 1));
    assign frameValid = datSync && parityOk;

    // Frame FSM, shifter and watchdog; a watchdog expiry overrides any coincident clock edge.
    always_comb begin
        state_d    = state_q;
        bitCnt_d   = bitCnt_q;
        shift_d    = shift_q;
        parity_d   = parity_q;
        rxData_d   = rxData_q;
        rxEn_d     = 1'b0;
        frameErr_d = 1'b0;
        wd_d       = (state_q == IDLE) ? '0 : wd_q + 1'b1;

        if (timeout) begin
            state_d    = IDLE;
            frameErr_d = 1'b1;
            wd_d       = '0;
        end else if (fallEdge) begin
            case (state_q)
                IDLE: begin
                    if (!datSync) begin
                        state_d  = DATA;
                        bitCnt_d = '0;
                        wd_d     = '0;
                    end else begin
                        frameErr_d = 1'b1;
                    end
                end
                DATA: begin
                    shift_d  = {datSync, shift_q[7:1]};
                    bitCnt_d = bitCnt_q + 1'b1;
                    if (bitCnt_q == 3'(DATA_BITS - 1)) begin
                        state_d = PARITY;
                    end
                end
                PARITY: begin
                    parity_d = datSync;
                    state_d  = STOP;
                end
                STOP: begin
                    state_d = IDLE;
                    if (frameValid) begin
                        rxData_d = shift_q;
                        rxEn_d   = 1'b1;
                    end else begin
                        frameErr_d = 1'b1;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    // State and output registers.
    always_ff @(posedge CLOCK_50 or negedge resetn) begin
        if (!resetn) begin
            state_q    <= IDLE;
            bitCnt_q   <= '0;
            shift_q    <= '0;
            parity_q   <= 1'b0;
            wd_q       <= '0;
            rxData_q   <= 8'h00;
            rxEn_q     <= 1'b0;
            frameErr_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            bitCnt_q   <= bitCnt_d;
            shift_q    <= shift_d;
            parity_q   <= parity_d;
            wd_q       <= wd_d;
            rxData_q   <= rxData_d;
            rxEn_q     <= rxEn_d;
            frameErr_q <= frameErr_d;
        end
    end

    assign received_data    = rxData_q;
    assign received_data_en = rxEn_q;
    assign frame_error      = frameErr_q;
    assign busy             = (state_q != IDLE);

endmodule

// File: tb/tb_ps2_frame_receiver.sv
// Self-checking bench for ps2_frame_receiver. Frames are driven onto the
// PS/2 pins bit by bit; each complete frame pushes its expected outcome
// (byte strobe or frame error) into a scoreboard that a negedge monitor
// drains whenever the receiver strobes. Honors PS2_PARITY_CHECK_EN.
module tb_ps2_frame_receiver;

    localparam int CLK_FREQ_HZ = 1000000;
    localparam int TIMEOUT_US  = 2000;
    localparam int FILTER_LEN  = 8;
    localparam int WD_TC       = CLK_FREQ_HZ / 1000000 * TIMEOUT_US;
    localparam int HALF_BIT    = 30;
`ifdef PS2_PARITY_CHECK_EN
    localparam bit CHECK_PAR = 1'b1;
`else
    localparam bit CHECK_PAR = 1'b0;
`endif

    typedef struct {
        logic       isErr;
        logic [7:0] data;
    } expEvent_t;

    logic       clock;
    logic       resetn;
    logic       clkDrv;
    logic       datDrv;
    wire        ps2Clk;
    wire        ps2Dat;
    logic [7:0] received_data;
    logic       received_data_en;
    logic       frame_error;
    logic       busy;

    int         checkCount;
    int         errorCount;
    int         cycleCount;
    int         busyRiseCycle;
    int         errCycle;
    logic       errSeen;
    logic       busyPrev;
    logic [7:0] lastGood;
    expEvent_t  expQ[$];

    assign ps2Clk = clkDrv;
    assign ps2Dat = datDrv;

    ps2_frame_receiver #(
        .CLK_FREQ_HZ (CLK_FREQ_HZ),
        .TIMEOUT_US  (TIMEOUT_US),
        .FILTER_LEN  (FILTER_LEN)
    ) dut (
        .CLOCK_50         (clock),
        .resetn           (resetn),
        .PS2_CLK          (ps2Clk),
        .PS2_DAT          (ps2Dat),
        .received_data    (received_data),
        .received_data_en (received_data_en),
        .frame_error      (frame_error),
        .busy             (busy)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Free-running cycle count used to time the watchdog.
    always @(posedge clock) cycleCount++;

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        checkCount++;
        if (actual !== expected) begin
            errorCount++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at cycle %0d", tag, actual, expected, cycleCount);
        end
    endtask

    // Drive the first nBits bits of a frame; a complete frame queues its expected outcome.
    task automatic applyStimulus(input logic [7:0] data, input logic badParity, input logic stopBit, input int nBits);
        logic [10:0] frame;
        logic        parBit;
        logic        valid;
        parBit = ~(^data) ^ badParity;
        frame  = {stopBit, parBit, data, 1'b0};
        if (nBits == 11) begin
            valid = stopBit && ((^{data, parBit}) || !CHECK_PAR);
            if (valid) begin
                expQ.push_back('{isErr: 1'b0, data: data});
                lastGood = data;
            end else begin
                expQ.push_back('{isErr: 1'b1, data: lastGood});
            end
        end
        for (int i = 0; i < nBits; i++) begin
            datDrv = frame[i];
            repeat (HALF_BIT / 2) @(posedge clock);
            clkDrv = 1'b0;
            repeat (HALF_BIT) @(posedge clock);
            if (i == 5) begin
                @(negedge clock);
                checkOutput("busyMidFrame", {31'd0, busy}, 32'd1);
            end
            clkDrv = 1'b1;
            repeat (HALF_BIT / 2) @(posedge clock);
        end
        datDrv = 1'b1;
    endtask

    // Scoreboard monitor: every strobe must match the oldest expected outcome.
    always @(negedge clock) begin
        expEvent_t e;
        if (busy && !busyPrev) busyRiseCycle = cycleCount;
        busyPrev = busy;
        if (frame_error) begin
            errSeen  = 1'b1;
            errCycle = cycleCount;
        end
        if (received_data_en || frame_error) begin
            if (expQ.size() == 0) begin
                checkOutput("unexpectedEvent", {30'd0, received_data_en, frame_error}, 32'd0);
            end else begin
                e = expQ.pop_front();
                checkOutput("eventKind", {30'd0, received_data_en, frame_error}, e.isErr ? 32'd1 : 32'd2);
                checkOutput("rxData", {24'd0, received_data}, {24'd0, e.data});
            end
        end
    end

    initial begin
        checkCount = 0;
        errorCount = 0;
        cycleCount = 0;
        busyRiseCycle = 0;
        errCycle = 0;
        errSeen  = 1'b0;
        busyPrev = 1'b0;
        lastGood = 8'h00;
        clkDrv = 1'b1;
        datDrv = 1'b1;
        resetn = 1'b0;
        repeat (5) @(posedge clock);
        @(negedge clock);
        checkOutput("resetData", {24'd0, received_data}, 32'd0);
        checkOutput("resetEn", {31'd0, received_data_en}, 32'd0);
        checkOutput("resetErr", {31'd0, frame_error}, 32'd0);
        checkOutput("resetBusy", {31'd0, busy}, 32'd0);
        resetn = 1'b1;
        repeat (20) @(posedge clock);

        $display("[TB] single frame 0x1C");
        applyStimulus(8'h1C, 1'b0, 1'b1, 11);

        $display("[TB] back-to-back F0, 1C");
        applyStimulus(8'hF0, 1'b0, 1'b1, 11);
        @(negedge clock);
        checkOutput("busyBetween", {31'd0, busy}, 32'd0);
        applyStimulus(8'h1C, 1'b0, 1'b1, 11);

        $display("[TB] 0x5A with wrong parity");
        applyStimulus(8'h5A, 1'b1, 1'b1, 11);

        $display("[TB] 0x6B with stop bit low");
        applyStimulus(8'h6B, 1'b0, 1'b0, 11);
        repeat (40) @(posedge clock);
        @(negedge clock);
        checkOutput("idleAfterBadStop", {31'd0, busy}, 32'd0);

        $display("[TB] clock stalls after 5 data bits");
        errSeen = 1'b0;
        expQ.push_back('{isErr: 1'b1, data: lastGood});
        applyStimulus(8'h33, 1'b0, 1'b1, 6);
        for (int k = 0; k < WD_TC + 500 && !errSeen; k++) @(posedge clock);
        checkOutput("timeoutSeen", {31'd0, errSeen}, 32'd1);
        checkOutput("timeoutLatency", errCycle - busyRiseCycle, WD_TC);
        repeat (10) @(posedge clock);
        applyStimulus(8'h74, 1'b0, 1'b1, 11);

        $display("[TB] 3-cycle glitch on PS2_CLK");
        clkDrv = 1'b0;
        repeat (3) @(posedge clock);
        clkDrv = 1'b1;
        repeat (20) @(posedge clock);
        @(negedge clock);
        checkOutput("glitchBusy", {31'd0, busy}, 32'd0);

        $display("[TB] reset mid-frame");
        applyStimulus(8'h55, 1'b0, 1'b1, 4);
        resetn = 1'b0;
        lastGood = 8'h00;
        @(negedge clock);
        checkOutput("midResetData", {24'd0, received_data}, 32'd0);
        checkOutput("midResetEn", {31'd0, received_data_en}, 32'd0);
        checkOutput("midResetErr", {31'd0, frame_error}, 32'd0);
        checkOutput("midResetBusy", {31'd0, busy}, 32'd0);
        repeat (3) @(posedge clock);
        resetn = 1'b1;
        repeat (WD_TC + 100) @(posedge clock);
        applyStimulus(8'hE0, 1'b0, 1'b1, 11);

        repeat (50) @(posedge clock);
        checkOutput("scoreboardEmpty", expQ.size(), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
        $finish;
    end

endmodule
